lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl.sv | 235 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit sequencer. Takes one decoded load or store from the
// core, checks it for illegal encodings and misalignment, and runs a
// request/grant/read-valid handshake with a word-organised memory. The core is
// stalled while an access is in flight. Each access ends in a single DONE cycle
// that carries the extended load data, or the abort cause.
module lsu_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              store_i,
    input  logic [2:0]        fun3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              err_o,
    output logic [1:0]        err_cause_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wstrb_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [2:0]          fun3_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                we_r;
    logic                err_r, err_s;
    logic [1:0]          cause_r, cause_s;
    logic [DATA_W-1:0]   rdata_r, rdata_s;
    logic                illegal_s, misalign_s;
    logic [3:0]          strb_s;
    logic [31:0]         lane_data_s;
    logic [31:0]         byte_sh_s, half_sh_s, ext_s;

    // Classify the incoming instruction: illegal encodings first, then alignment.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (load_i && store_i) begin
            illegal_s = 1'b1;
        end else if (load_i) begin
            case (fun3_i)
                3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
                default:                illegal_s = 1'b0;
            endcase
        end else if (store_i) begin
            illegal_s = (fun3_i >= 3'b011);
        end else begin
            illegal_s = 1'b0;
        end
        case (fun3_i[1:0])
            2'b01:   misalign_s = addr_i[0];
            2'b10:   misalign_s = (addr_i[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
    end

    // Store lane placement from the latched size and low address bits.
    always_comb begin
        strb_s      = 4'b0000;
        lane_data_s = 32'h0000_0000;
        case (fun3_r[1:0])
            2'b00: begin
                strb_s      = 4'b0001 << addr_r[1:0];
                lane_data_s = {4{wdata_r[7:0]}};
            end
            2'b01: begin
                strb_s      = addr_r[1] ? 4'b1100 : 4'b0011;
                lane_data_s = {2{wdata_r[15:0]}};
            end
            2'b10: begin
                strb_s      = 4'b1111;
                lane_data_s = wdata_r[31:0];
            end
            default: begin
                strb_s      = 4'b0000;
                lane_data_s = 32'h0000_0000;
            end
        endcase
    end

    // Load lane selection and sign/zero extension of the returned word.
    always_comb begin
        byte_sh_s = mem_rdata_i >> {addr_r[1:0], 3'b000};
        half_sh_s = mem_rdata_i >> {addr_r[1], 4'b0000};
        case (fun3_r)
            3'b000:  ext_s = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
            3'b100:  ext_s = {24'h00_0000, byte_sh_s[7:0]};
            3'b001:  ext_s = {{16{half_sh_s[15]}}, half_sh_s[15:0]};
            3'b101:  ext_s = {16'h0000, half_sh_s[15:0]};
            3'b010:  ext_s = mem_rdata_i;
            default: ext_s = 32'h0000_0000;
        endcase
    end

    // Next-state logic; also builds the DONE-cycle error and load result.
    always_comb begin
        state_s = state_r;
        err_s   = 1'b0;
        cause_s = 2'b00;
        rdata_s = '0;
        case (state_r)
            ST_IDLE: begin
                if (load_i || store_i) begin
                    if (illegal_s) begin
                        state_s = ST_DONE;
                        err_s   = 1'b1;
                        cause_s = 2'b10;
                    end else if (misalign_s) begin
                        state_s = ST_DONE;
                        err_s   = 1'b1;
                        cause_s = 2'b01;
                    end else begin
                        state_s = ST_REQ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_gnt_i) begin
                    state_s = we_r ? ST_DONE : ST_WAIT;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                    cause_s = 2'b11;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    state_s = ST_DONE;
                    rdata_s = ext_s;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = ST_DONE;
                    err_s   = 1'b1;
                    cause_s = 2'b11;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State, timeout counter and DONE-cycle result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            err_r   <= 1'b0;
            cause_r <= 2'b00;
            rdata_r <= '0;
        end else begin
            state_r <= state_s;
            err_r   <= err_s;
            cause_r <= cause_s;
            rdata_r <= rdata_s;
            if ((state_s == state_r) && ((state_r == ST_REQ) || (state_r == ST_WAIT))) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= '0;
            end
        end
    end

    // Capture the instruction operands when an access is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fun3_r  <= 3'b000;
            addr_r  <= '0;
            wdata_r <= '0;
            we_r    <= 1'b0;
        end else if ((state_r == ST_IDLE) && (load_i || store_i)) begin
            fun3_r  <= fun3_i;
            addr_r  <= addr_i;
            wdata_r <= wdata_i;
            we_r    <= store_i;
        end else begin
            fun3_r  <= fun3_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            we_r    <= we_r;
        end
    end

    // Output decode from registered state; only stall sees the live strobes.
    always_comb begin
        stall_o     = ((state_r == ST_IDLE) && (load_i || store_i)) ||
                      (state_r == ST_REQ) || (state_r == ST_WAIT);
        done_o      = (state_r == ST_DONE);
        err_o       = err_r;
        err_cause_o = cause_r;
        rdata_o     = rdata_r;
        mem_req_o   = (state_r == ST_REQ);
        mem_we_o    = (state_r == ST_REQ) && we_r;
        if (state_r == ST_REQ) begin
            mem_addr_o = {addr_r[ADDR_W-1:2], 2'b00};
        end else begin
            mem_addr_o = '0;
        end
        if ((state_r == ST_REQ) && we_r) begin
            mem_wstrb_o = strb_s;
            mem_wdata_o = lane_data_s;
        end else begin
            mem_wstrb_o = 4'b0000;
            mem_wdata_o = '0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of the access rules.
module tb_lsu_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_i = 1'b0, store_i = 1'b0;
    logic [2:0]  fun3_i = 3'b000;
    logic [31:0] addr_i = 32'h0, wdata_i = 32'h0;
    logic        stall_o, done_o, err_o, mem_req_o, mem_we_o;
    logic [1:0]  err_cause_o;
    logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_wstrb_o;
    logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
    logic [31:0] mem_rdata_i = 32'h0;

    int n_chk = 0;
    int n_err = 0;

    lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_i(load_i), .store_i(store_i), .fun3_i(fun3_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .rdata_o(rdata_o),
        .err_o(err_o), .err_cause_o(err_cause_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: model computes expectations, bench plays the memory.
    // gd = REQ cycles without grant before grant; rd = WAIT cycles before rvalid.
    task automatic run_access(input logic ld, input logic st, input logic [2:0] f3,
                              input logic [31:0] ad, input logic [31:0] wd,
                              input int gd, input int rd, input logic [31:0] rdat);
        logic        ill, mis, acc, is_ld, tmo, seen;
        int          bytes, e_req, e_wait, nreq, nwait, ncyc;
        logic [1:0]  e_cause;
        logic [31:0] e_strb, e_wdata, e_rdata, mask, lane;

        ill   = (ld && st) || (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) ||
                (st && f3 >= 3'd3);
        bytes = 1 << int'(f3[1:0]);
        mis   = !ill && ((ad % bytes) != 0);
        acc   = !ill && !mis;
        is_ld = ld && !st;
        e_req  = acc ? ((gd < TIMEOUT) ? gd + 1 : TIMEOUT) : 0;
        e_wait = (acc && is_ld && gd < TIMEOUT) ? ((rd < TIMEOUT) ? rd + 1 : TIMEOUT) : 0;
        tmo    = acc && ((gd >= TIMEOUT) || (is_ld && rd >= TIMEOUT));
        e_cause = ill ? 2'd2 : (mis ? 2'd1 : (tmo ? 2'd3 : 2'd0));
        e_strb  = ((32'd1 << bytes) - 32'd1) << (ad % 4);
        e_wdata = (bytes == 1) ? wd[7:0] * 32'h0101_0101 :
                  (bytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        lane    = rdat >> (8 * (ad % 4));
        mask    = (bytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
        e_rdata = lane & mask;
        if (!f3[2] && bytes < 4 && ((e_rdata & ((mask + 32'd1) >> 1)) != 0))
            e_rdata = e_rdata | ~mask;
        if (!(is_ld && acc && !tmo))
            e_rdata = 32'h0;

        @(posedge clk); #1;
        load_i = ld; store_i = st; fun3_i = f3; addr_i = ad; wdata_i = wd;
        @(negedge clk);
        chk("stall_issue", stall_o, 32'd1);
        chk("req_issue", mem_req_o, 32'd0);
        @(posedge clk); #1;
        load_i = 1'b0; store_i = 1'b0;
        nreq = 0; nwait = 0; ncyc = 0; seen = 1'b0;
        while (!seen && ncyc < 64) begin
            @(negedge clk);
            ncyc++;
            if (done_o) begin
                seen = 1'b1;
                mem_gnt_i = 1'b0;
                mem_rvalid_i = 1'b0;
                chk("err", err_o, (e_cause != 2'd0) ? 32'd1 : 32'd0);
                chk("cause", err_cause_o, e_cause);
                chk("rdata", rdata_o, e_rdata);
                chk("stall_done", stall_o, 32'd0);
                chk("req_done", mem_req_o, 32'd0);
            end else begin
                chk("err_busy", err_o, 32'd0);
                if (mem_req_o) begin
                    nreq++;
                    chk("stall_req", stall_o, 32'd1);
                    if (nreq == 1) begin
                        chk("addr", mem_addr_o, {ad[31:2], 2'b00});
                        chk("we", mem_we_o, st);
                        chk("wstrb", mem_wstrb_o, st ? e_strb : 32'd0);
                        chk("wdata", mem_wdata_o, st ? e_wdata : 32'd0);
                    end
                    mem_gnt_i = (nreq - 1 == gd);
                    mem_rvalid_i = 1'($urandom_range(0, 1));
                    mem_rdata_i = $urandom;
                end else begin
                    mem_gnt_i = 1'b0;
                    if (stall_o) begin
                        nwait++;
                        mem_rvalid_i = (nwait - 1 == rd);
                        mem_rdata_i = (nwait - 1 == rd) ? rdat : $urandom;
                    end else begin
                        mem_rvalid_i = 1'b0;
                    end
                end
            end
        end
        mem_gnt_i = 1'b0;
        mem_rvalid_i = 1'b0;
        chk("done_seen", seen, 32'd1);
        chk("req_cycles", nreq, e_req);
        chk("wait_cycles", nwait, e_wait);
        chk("done_cycle", ncyc, e_req + e_wait + 1);
    endtask

    logic        r_ld, r_st;
    logic [2:0]  r_f3;
    logic [31:0] r_ad;
    int          r_gd, r_rd, r_k;

    initial begin
        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", done_o, 32'd0);
        chk("rst_req", mem_req_o, 32'd0);
        chk("rst_err", err_o, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_stall", stall_o, 32'd0);
        chk("rst_wstrb", mem_wstrb_o, 32'd0);
        rst_n = 1'b1;

        // Directed scenarios
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 0, 2, 32'h8012_3456);
        run_access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 0, 2, 32'h8012_3456);
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 1, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, TIMEOUT, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, TIMEOUT - 1, 0, 32'hCAFE_F00D);
        run_access(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h0, 0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b011, 32'h0000_0200, 32'h0, 0, 0, 32'h0);
        run_access(1'b1, 1'b0, 3'b101, 32'h0000_0302, 32'h0, 2, TIMEOUT, 32'h0);
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_0302, 32'h0, 0, TIMEOUT - 1, 32'h9ABC_0000);

        // Reset pulse while waiting for read data
        @(posedge clk); #1;
        load_i = 1'b1; fun3_i = 3'b010; addr_i = 32'h0000_0300;
        @(posedge clk); #1;
        load_i = 1'b0; mem_gnt_i = 1'b1;
        @(posedge clk); #1;
        mem_gnt_i = 1'b0;
        chk("wait_stall", stall_o, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_stall", stall_o, 32'd0);
        chk("arst_req", mem_req_o, 32'd0);
        chk("arst_done", done_o, 32'd0);
        chk("arst_addr", mem_addr_o, 32'd0);
        mem_rvalid_i = 1'b1;
        mem_rdata_i = 32'h1111_1111;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_done_after_rst", done_o, 32'd0);
        end
        mem_rvalid_i = 1'b0;
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h0BAD_F00D, 0, 0, 32'h0);

        // Randomized accesses
        for (int i = 0; i < 40; i++) begin
            r_k = $urandom_range(0, 19);
            r_ld = (r_k < 10) || (r_k == 19);
            r_st = (r_k >= 10);
            r_f3 = 3'($urandom_range(0, 7));
            if (r_st && ($urandom_range(0, 1) == 1)) r_f3 = 3'($urandom_range(0, 2));
            r_ad = $urandom;
            if ($urandom_range(0, 1) == 1) r_ad[1:0] = 2'b00;
            case ($urandom_range(0, 5))
                4:       r_gd = TIMEOUT - 1;
                5:       r_gd = TIMEOUT;
                default: r_gd = $urandom_range(0, 3);
            endcase
            case ($urandom_range(0, 5))
                4:       r_rd = TIMEOUT - 1;
                5:       r_rd = TIMEOUT;
                default: r_rd = $urandom_range(0, 4);
            endcase
            run_access(r_ld, r_st, r_f3, r_ad, $urandom, r_gd, r_rd, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
